// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: command mode encodings, FSM states
// and the lit-to-pin polarity mapping.
package led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_ON     = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_ROTATE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PH_ON  = 2'd1,
    PH_OFF = 2'd2
  } state_e;

  // Maps a logical "lit" bit to the pin level that lights the LED.
  function automatic logic led_drive(input logic lit, input bit active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Command handshake between a host-side requester and the LED sequencer.
interface led_sequencer_if #(
  parameter int NUM_LED = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_mode;
  logic [NUM_LED-1:0] cmd_mask;
  logic [7:0]         cmd_period;
  logic [7:0]         cmd_count;

  modport master (
    output cmd_valid, cmd_mode, cmd_mask, cmd_period, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_mask, cmd_period, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks, restartable by clear.
module tick_gen #(
  parameter int TICK_DIV = 2_400_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = !clear && (cnt_q == LAST);
endmodule

// File: rtl/led_sequencer.sv
// Command-driven LED pattern controller: OFF/ON immediately, BLINK and ROTATE
// sequenced on prescaled ticks, with a done pulse when a finite command ends.
module led_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV       = 2_400_000,
  parameter int NUM_LED        = 3,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  led_sequencer_if.slave      cmd,
  output logic                busy,
  output logic                done,
  output logic [NUM_LED-1:0]  led
);
  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [NUM_LED-1:0] pattern_q, pattern_d;
  logic [7:0]         period_q, period_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         phase_q, phase_d;
  logic               done_q, done_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_LED-1:0] lit_d;
  logic               accept, tick, phase_end, finish;

  // Infinite commands stay preemptible; finite ones must run to completion.
  assign cmd.cmd_ready = (state_q == IDLE) || (count_q == 8'd0);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    count_d   = count_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    finish    = 1'b0;
    phase_end = tick && (phase_q == period_q - 8'd1);

    if (accept) begin
      mode_d   = cmd.cmd_mode;
      period_d = (cmd.cmd_period == 8'd0) ? 8'd1 : cmd.cmd_period;
      count_d  = cmd.cmd_count;
      phase_d  = 8'd0;
      case (cmd.cmd_mode)
        MODE_OFF: begin state_d = IDLE;  pattern_d = '0;           done_d = 1'b1; end
        MODE_ON:  begin state_d = IDLE;  pattern_d = cmd.cmd_mask; done_d = 1'b1; end
        default:  begin state_d = PH_ON; pattern_d = cmd.cmd_mask;                end
      endcase
    end else if ((state_q != IDLE) && tick) begin
      if (!phase_end) begin
        phase_d = phase_q + 8'd1;
      end else begin
        phase_d = 8'd0;
        if (mode_q == MODE_ROTATE) begin
          pattern_d = {pattern_q[NUM_LED-2:0], pattern_q[NUM_LED-1]};
          if (count_q == 8'd1)      finish  = 1'b1;
          else if (count_q != 8'd0) count_d = count_q - 8'd1;
        end else if (state_q == PH_ON) begin
          state_d = PH_OFF;
        end else begin
          if (count_q == 8'd1) begin
            finish = 1'b1;
          end else begin
            if (count_q != 8'd0) count_d = count_q - 8'd1;
            state_d = PH_ON;
          end
        end
      end
      if (finish) begin
        state_d   = IDLE;
        pattern_d = '0;
        count_d   = 8'd0;
        done_d    = 1'b1;
      end
    end

    // ON holds its mask in IDLE; finished or OFF commands leave pattern cleared.
    lit_d = (state_d == PH_OFF) ? '0 : pattern_d;
    for (int i = 0; i < NUM_LED; i++) led_d[i] = led_drive(lit_d[i], LED_ACTIVE_LOW);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_OFF;
      pattern_q <= '0;
      period_q  <= 8'd1;
      count_q   <= 8'd0;
      phase_q   <= 8'd0;
      done_q    <= 1'b0;
      led_q     <= {NUM_LED{LED_ACTIVE_LOW}};
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign led  = led_q;
endmodule
